// File: rtl/axi4_lite_write_master_if.sv
// AXI4-lite write-channel bundle (AW, W, B) shared by the write master and the write slave.
interface axi4_lite_write_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/axi4_lite_write_master.sv
// Single-outstanding AXI4-lite write master: latches one store request, drives AW/W,
// collects B and reports completion with a one-cycle done pulse.
module axi4_lite_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]            wr_byte_en,
    output logic                  wr_done,
    output logic [1:0]            wr_resp,
    output logic                  wr_err,
    axi4_lite_write_master_if.master m_axi
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_DATA,
        ST_ADDR_ONLY,
        ST_BRESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_strb;
    logic                  r_aw_done;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_wr_ready;
    logic                  r_wr_done;
    logic [1:0]            r_wr_resp;
    logic                  r_wr_err;

    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = r_awvalid && m_axi.M_AXI_AWREADY;
    assign w_w_hs  = r_wvalid && m_axi.M_AXI_WREADY;

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_aw_done  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_wr_ready <= 1'b1;
            r_wr_done  <= 1'b0;
            r_wr_resp  <= 2'b00;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            r_wr_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_req && r_wr_ready) begin
                        r_addr     <= wr_addr;
                        r_data     <= wr_data;
                        r_strb     <= wr_byte_en;
                        r_aw_done  <= 1'b0;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_wr_ready <= 1'b0;
                        r_state    <= ST_ADDR_DATA;
                    end
                end
                ST_ADDR_DATA: begin
                    // AWVALID stays up past its own handshake; r_aw_done remembers it was taken.
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        if (m_axi.M_AXI_AWREADY || r_aw_done) begin
                            r_awvalid <= 1'b0;
                            r_bready  <= 1'b1;
                            r_state   <= ST_BRESP;
                        end else begin
                            r_state <= ST_ADDR_ONLY;
                        end
                    end else if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                end
                ST_ADDR_ONLY: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_BRESP;
                    end
                end
                ST_BRESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        r_wr_resp  <= m_axi.M_AXI_BRESP;
                        r_wr_done  <= 1'b1;
                        r_wr_err   <= (m_axi.M_AXI_BRESP != 2'b00);
                        r_bready   <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready            = r_wr_ready;
    assign wr_done             = r_wr_done;
    assign wr_resp             = r_wr_resp;
    assign wr_err              = r_wr_err;
    assign m_axi.M_AXI_AWADDR  = r_addr;
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = r_data;
    assign m_axi.M_AXI_WSTRB   = r_strb;
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;

endmodule

// File: doc/axi4_lite_write_master.md
# axi4_lite_write_master

Single-outstanding AXI4-lite write master that sits directly upstream of the AXI4-lite write slave. It accepts a store request on a simple ready/request interface and registers address, data and strobe. It then drives the AW and W channels and collects the B response. On completion it returns a one-cycle done pulse with the response code.

## Interface
- ADDR_WIDTH, 32, width of request address and AWADDR
- DATA_WIDTH, 32, width of request data and WDATA
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- wr_req  in  1  request valid; a request is accepted when wr_req && wr_ready
- wr_ready  out  1  master idle and able to accept a request
- wr_addr  in  ADDR_WIDTH  store address
- wr_data  in  DATA_WIDTH  store data
- wr_byte_en  in  4  store byte enables
- wr_done  out  1  one-cycle pulse when a write completes
- wr_resp  out  2  BRESP of the completed write; valid while wr_done=1, held until next completion
- wr_err  out  1  equals wr_done && (wr_resp != 2'b00)
- M_AXI_AWADDR  out  ADDR_WIDTH  write address
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  slave accepts address
- M_AXI_WDATA  out  DATA_WIDTH  write data
- M_AXI_WSTRB  out  4  write strobes
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  slave accepts data
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  response valid
- M_AXI_BREADY  out  1  master accepts response

## Operation
- FSM states: ST_IDLE, ST_ADDR_DATA, ST_ADDR_ONLY, ST_BRESP. Next state is registered and all outputs decode from it.
- ST_IDLE
  - wr_ready=1.
  - On accept, latch wr_addr, wr_data and wr_byte_en into holding registers and go to ST_ADDR_DATA.
  - wr_req while not idle is ignored and never queued.
- ST_ADDR_DATA
  - AWVALID=1 and WVALID=1. AWADDR, WDATA and WSTRB come from the holding registers.
  - If WVALID && WREADY in a cycle where AWREADY=1, go to ST_BRESP.
  - If WVALID && WREADY with AWREADY=0, go to ST_ADDR_ONLY.
  - An AW handshake alone does not drop AWVALID. AWVALID and AWADDR are held until the W handshake, because the downstream write slave samples AWADDR during its data phase.
- ST_ADDR_ONLY
  - AWVALID=1 and WVALID=0.
  - On AWREADY, go to ST_BRESP.
- ST_BRESP
  - BREADY=1.
  - On BVALID, capture BRESP into wr_resp, set wr_done for the next cycle, and go to ST_IDLE.
- Holding registers are stable from accept until ST_IDLE is re-entered. AXI payload outputs are driven from them, never from the request inputs.
- BRESP values SLVERR and DECERR are reported through wr_err only. There is no retry.

## Timing
- Reset values:
  - state ST_IDLE
  - wr_ready=1
  - wr_done=0, wr_err=0, wr_resp=2'b00
  - AWVALID=0, WVALID=0, BREADY=0
  - AWADDR, WDATA and WSTRB all 0
- Reset asserted mid-transaction: the master abandons it, returns to ST_IDLE on the next edge, and emits no wr_done.
- Accept at edge N: AWVALID and WVALID are high from cycle N+1.
- Best case against an always-ready slave:
  - AW and W handshake in N+1.
  - BREADY is high in N+2; with BVALID also high in N+2, wr_done is high in N+3 and wr_ready is high in N+3.
  - Back-to-back accept is possible in N+3.
- Against the team's write slave:
  - AW handshake in N+1, W handshake in N+2.
  - BREADY high in N+3 and BVALID high in N+3.
  - wr_done in N+4.
- VALID never depends combinationally on READY.
- Once AWVALID or WVALID is asserted, it and its payload are held until its handshake.
- BREADY may wait indefinitely for BVALID; there is no timeout.

## Test plan
- Always-ready slave, BVALID tied high:
  - Stimulus: request addr=0x0000_1000, data=0xDEAD_BEEF, byte_en=4'hF at edge 0.
  - Required: AWVALID/WVALID high in cycle 1 with matching payload; wr_done in cycle 3, wr_resp=00, wr_err=0.
- Team write-slave model:
  - Stimulus: request addr=0x20, data=0x1234_5678, byte_en=4'b0011.
  - Required: AWVALID stays high through the W handshake in cycle 2; slave memory word 0x20 gets bytes 0x78,0x56; wr_done in cycle 4.
- WREADY before AWREADY:
  - Stimulus: WREADY=1 in cycle 1, AWREADY=0 until cycle 4.
  - Required: WVALID drops in cycle 2; AWVALID is held through cycle 4; BREADY high from cycle 5.
- Error response:
  - Stimulus: BRESP=2'b10 with BVALID.
  - Required: wr_done=1 and wr_err=1 for exactly one cycle; wr_resp=10 is held afterwards.
- Busy and reset:
  - Stimulus: wr_req held high during a transfer; then rst pulsed while in ST_BRESP.
  - Required: no second transfer is started while busy; after reset, AWVALID/WVALID/BREADY=0, wr_ready=1, and no wr_done pulse.
